// File: rtl/onehot_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | onehot_arb_pkg : shared types, select encodings and helpers for the        |
// |                  4-way one-hot round-robin arbiter.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package onehot_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Source 0 sits in the MSB of the select bus.
    localparam logic [3:0] SEL_SRC0 = 4'b1000;
    localparam logic [3:0] SEL_SRC1 = 4'b0100;
    localparam logic [3:0] SEL_SRC2 = 4'b0010;
    localparam logic [3:0] SEL_SRC3 = 4'b0001;

    function automatic logic [3:0] idx2onehot(input int idx);
        logic [3:0] r_sel;
        case (idx)
            0:       r_sel = SEL_SRC0;
            1:       r_sel = SEL_SRC1;
            2:       r_sel = SEL_SRC2;
            3:       r_sel = SEL_SRC3;
            default: r_sel = 4'b0000;
        endcase
        return r_sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick4 : combinational round-robin picker, first requester at or after   |
// |            ptr (mod 4).                                                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       found
);

    logic [1:0] w_cand;

    // Scan from the farthest offset down so the nearest hit wins last.
    always_comb begin
        idx    = ptr;
        found  = 1'b0;
        w_cand = ptr;
        for (int i = 3; i >= 0; i--) begin
            w_cand = ptr + 2'(i);
            if (req[w_cand]) begin
                idx   = w_cand;
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/onehot_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | onehot_rr_arbiter : 4-way round-robin arbiter driving a one-hot select and |
// |                     captured payload over valid/ready, with grant strobe.  |
// | Option macro ONEHOT_ARB_LOCK_EN: let a winner hold for MAX_BURST transfers.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module onehot_rr_arbiter
    import onehot_arb_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data_0,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic [WIDTH-1:0] data_3,
    output logic [3:0]       gnt,
    output logic [3:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    arb_state_e       r_state, w_state_nxt;
    logic [3:0]       r_sel, w_sel_nxt;
    logic [WIDTH-1:0] r_data, w_data_nxt;
    logic [1:0]       r_idx, w_idx_nxt;
    logic [1:0]       r_ptr, w_ptr_nxt;
    logic [1:0]       w_pick_idx;
    logic             w_pick_found;
    logic [WIDTH-1:0] w_pick_data;
    logic             w_hs;

`ifdef ONEHOT_ARB_LOCK_EN
    localparam int c_CNT_W = $clog2(MAX_BURST + 1);
    logic [c_CNT_W-1:0] r_burst_cnt, w_burst_nxt;
    logic               w_burst_more;
    assign w_burst_more = (int'(r_burst_cnt) + 1) < MAX_BURST;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (MAX_BURST > 0);
`endif

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    always_comb begin
        w_pick_data = data_0;
        case (w_pick_idx)
            2'd0:    w_pick_data = data_0;
            2'd1:    w_pick_data = data_1;
            2'd2:    w_pick_data = data_2;
            default: w_pick_data = data_3;
        endcase
    end

    // gnt is indexed by source number, i.e. the bit-reverse of sel.
    assign w_hs      = (r_state == BUSY) && out_ready;
    assign gnt       = w_hs ? (4'b0001 << r_idx) : 4'b0000;
    assign sel       = r_sel;
    assign out_valid = (r_state == BUSY);
    assign out_data  = r_data;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_data_nxt  = r_data;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
`ifdef ONEHOT_ARB_LOCK_EN
        w_burst_nxt = r_burst_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = BUSY;
                    w_sel_nxt   = idx2onehot(int'(w_pick_idx));
                    w_data_nxt  = w_pick_data;
                    w_idx_nxt   = w_pick_idx;
`ifdef ONEHOT_ARB_LOCK_EN
                    // The locked source dropped out; its burst is over.
                    if (w_pick_idx != r_ptr) begin
                        w_burst_nxt = '0;
                    end
`endif
                end
            end
            BUSY: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                    w_sel_nxt   = 4'b0000;
`ifdef ONEHOT_ARB_LOCK_EN
                    if (w_burst_more) begin
                        w_ptr_nxt   = r_idx;
                        w_burst_nxt = r_burst_cnt + 1'b1;
                    end else begin
                        w_ptr_nxt   = r_idx + 2'd1;
                        w_burst_nxt = '0;
                    end
`else
                    w_ptr_nxt   = r_idx + 2'd1;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sel       <= 4'b0000;
            r_data      <= '0;
            r_idx       <= 2'd0;
            r_ptr       <= 2'd0;
`ifdef ONEHOT_ARB_LOCK_EN
            r_burst_cnt <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_data      <= w_data_nxt;
            r_idx       <= w_idx_nxt;
            r_ptr       <= w_ptr_nxt;
`ifdef ONEHOT_ARB_LOCK_EN
            r_burst_cnt <= w_burst_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_onehot_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_onehot_rr_arbiter : directed bench with a transaction-level model of    |
// |                        the arbiter checked every cycle.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_onehot_rr_arbiter;

    localparam int W  = 5;
    localparam int MB = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         out_ready;
    logic [3:0]   req;
    logic [W-1:0] data [4];
    logic [3:0]   gnt;
    logic [3:0]   sel;
    logic         out_valid;
    logic [W-1:0] out_data;

    always #5 clk = ~clk;

    onehot_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_0    (data[0]),
        .data_1    (data[1]),
        .data_2    (data[2]),
        .data_3    (data[3]),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  chk_en   = 1'b0;
    int  glog[$];
    int  exp_q[$];

    // Model: one pending transfer (source, payload) and the next-priority source.
    bit           m_busy  = 1'b0;
    int           m_idx   = 0;
    int           m_ptr   = 0;
    int           m_burst = 0;
    logic [W-1:0] m_data  = '0;

    function automatic int pick(input logic [3:0] r, input int p);
        int k;
        k = -1;
        for (int off = 0; off < 4; off++) begin
            if (k < 0 && r[(p + off) % 4]) k = (p + off) % 4;
        end
        return k;
    endfunction

    function automatic logic [3:0] exp_sel();
        logic [3:0] top;
        top = 4'b1000;
        return m_busy ? (top >> m_idx) : 4'b0000;
    endfunction

    function automatic logic [3:0] exp_gnt();
        logic [3:0] one;
        one = 4'b0001;
        return (m_busy && out_ready) ? (one << m_idx) : 4'b0000;
    endfunction

    function automatic int gnt_idx(input logic [3:0] g);
        case (g)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_idx   <= 0;
            m_ptr   <= 0;
            m_burst <= 0;
            m_data  <= '0;
        end else if (!m_busy) begin
            if (req != 4'b0000) begin
                m_busy <= 1'b1;
                m_idx  <= pick(req, m_ptr);
                m_data <= data[pick(req, m_ptr)];
`ifdef ONEHOT_ARB_LOCK_EN
                if (pick(req, m_ptr) != m_ptr) m_burst <= 0;
`endif
            end
        end else if (out_ready) begin
            m_busy <= 1'b0;
`ifdef ONEHOT_ARB_LOCK_EN
            if (m_burst + 1 < MB) begin
                m_ptr   <= m_idx;
                m_burst <= m_burst + 1;
            end else begin
                m_ptr   <= (m_idx + 1) % 4;
                m_burst <= 0;
            end
`else
            m_ptr <= (m_idx + 1) % 4;
`endif
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic check_seq(input string nm);
        bit ok;
        ok = (glog.size() == exp_q.size());
        if (ok) begin
            for (int i = 0; i < exp_q.size(); i++) if (glog[i] != exp_q[i]) ok = 1'b0;
        end
        n_checks++;
        if (!ok) begin
            $display("FAIL %s: got %0d grants (first %0d) expected %0d grants (first %0d)", nm,
                     glog.size(), (glog.size() > 0) ? glog[0] : -1,
                     exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : -1);
        end else begin
            n_pass++;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_out_valid", 32'(out_valid), 32'(m_busy));
            check("cyc_sel", 32'(sel), 32'(exp_sel()));
            check("cyc_out_data", 32'(out_data), 32'(m_data));
            check("cyc_gnt", 32'(gnt), 32'(exp_gnt()));
            if (gnt != 4'b0000) glog.push_back(gnt_idx(gnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        step();
        rst_n     = 1'b1;
        glog.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) data[i] = '0;

        // Reset held two cycles with all sources requesting
        step();
        chk_en = 1'b1;
        @(negedge clk);
        check("t1_sel", 32'(sel), 32'h0);
        check("t1_valid", 32'(out_valid), 32'h0);
        check("t1_gnt", 32'(gnt), 32'h0);
        step();
        rst_n = 1'b1;
        req   = 4'b0000;
        step();

        // Single request from source 0
        req     = 4'b0001;
        data[0] = 5'h15;
        step();
        @(negedge clk);
        check("t2_sel", 32'(sel), 32'h8);
        check("t2_data", 32'(out_data), 32'h15);
        check("t2_gnt", 32'(gnt), 32'h1);
        check("t2_valid", 32'(out_valid), 32'h1);
        step();
        req = 4'b0000;
        @(negedge clk);
        check("t2_valid_after", 32'(out_valid), 32'h0);

        // Fairness with all four requesting
        do_reset();
        req       = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) data[i] = 5'(i + 3);
        repeat (10) step();
        req   = 4'b0000;
        exp_q = '{0, 1, 2, 3, 0};
        check_seq("t3_rr_order");

        // Backpressure holds sel/data while inputs change
        do_reset();
        req       = 4'b0100;
        data[2]   = 5'h0A;
        out_ready = 1'b0;
        step();
        data[2] = 5'h1F;
        req     = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_sel_hold", 32'(sel), 32'h2);
            check("t4_data_hold", 32'(out_data), 32'h0A);
            check("t4_gnt_low", 32'(gnt), 32'h0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_gnt", 32'(gnt), 32'h4);
        step();
        @(negedge clk);
        check("t4_valid_after", 32'(out_valid), 32'h0);
        check("t4_gnt_after", 32'(gnt), 32'h0);

        // Reset while source 1 is pending
        do_reset();
        req       = 4'b0010;
        data[1]   = 5'h07;
        out_ready = 1'b0;
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_sel_pending", 32'(sel), 32'h4);
        step();
        rst_n     = 1'b1;
        req       = 4'b0011;
        data[0]   = 5'h11;
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_valid_dropped", 32'(out_valid), 32'h0);
        check("t5_sel_cleared", 32'(sel), 32'h0);
        step();
        @(negedge clk);
        check("t5_sel_src0", 32'(sel), 32'h8);
        check("t5_data_src0", 32'(out_data), 32'h11);
        step();
        req   = 4'b0000;
        exp_q = '{0};
        check_seq("t5_grants");

        // Sources 0 and 3 requesting continuously
        do_reset();
        req       = 4'b1001;
        out_ready = 1'b1;
        repeat (12) step();
        req = 4'b0000;
`ifdef ONEHOT_ARB_LOCK_EN
        exp_q = '{0, 0, 3, 3, 0, 0};
`else
        exp_q = '{0, 3, 0, 3, 0, 3};
`endif
        check_seq("t6_pair_order");

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
